// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: pattern mode encoding.
package led_seq_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BINARY  = 2'd0,
        MODE_ROTATE  = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

endpackage

// File: rtl/led_pattern_sequencer_prescaler.sv
// Divisor register and tick down-divider; a divisor of 0 behaves as 1.
module tick_prescaler #(
    parameter int DIV_BITS    = 22,
    parameter int DEFAULT_DIV = 2**22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_BITS-1:0] div,
    input  logic                load,
    output logic                tick
);

    // One extra bit so the reset divisor may be 2**DIV_BITS exactly.
    localparam logic [DIV_BITS:0] DEF_DIV = (DIV_BITS+1)'(DEFAULT_DIV);
    localparam logic [DIV_BITS:0] ONE     = {{DIV_BITS{1'b0}}, 1'b1};

    logic [DIV_BITS:0] div_q;
    logic [DIV_BITS:0] div_eff;
    logic [DIV_BITS:0] count_q;
    logic              tc;

    assign div_eff = (div_q == '0) ? ONE : div_q;
    assign tc      = (count_q >= div_eff - ONE);
    assign tick    = tc & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= DEF_DIV;
            count_q <= '0;
        end else begin
            if (load)
                div_q <= {1'b0, div};
            count_q <= tc ? '0 : count_q + ONE;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: prescaled pattern stepping with a valid/ready config
// port whose changes are applied only on tick boundaries.
//   mode         | meaning
//   MODE_BINARY  | led counts up in binary, wraps to 0
//   MODE_ROTATE  | single lit LED rotates left with wrap
//   MODE_BOUNCE  | single lit LED sweeps up then down
//   MODE_BREATHE | all LEDs PWM'd with a triangle-ramped duty
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS    = 5,
    parameter int DIV_BITS    = 22,
    parameter int DEFAULT_DIV = 2**22,
    parameter int PWM_BITS    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [DIV_BITS-1:0] cfg_div,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    localparam logic [NUM_LEDS-1:0] PAT_ONE = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] PAT_MSB = PAT_ONE << (NUM_LEDS-1);
    localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    mode_t               mode_q, mode_d;
    mode_t               pend_mode_q, pend_mode_d;
    logic [DIV_BITS-1:0] pend_div_q, pend_div_d;
    logic                pend_q, pend_d;
    logic [NUM_LEDS-1:0] pat_q, pat_d;
    logic                bdir_q, bdir_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                ddir_q, ddir_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                tick_i;
    logic                apply;

    tick_prescaler #(
        .DIV_BITS    (DIV_BITS),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .div  (pend_div_q),
        .load (apply),
        .tick (tick_i)
    );

    assign apply     = tick_i & pend_q;
    assign cfg_ready = ~pend_q;
    assign tick      = tick_i;
    assign led       = led_q;

    always_comb begin
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pend_div_d  = pend_div_q;
        pend_d      = pend_q;
        pat_d       = pat_q;
        bdir_d      = bdir_q;
        duty_d      = duty_q;
        ddir_d      = ddir_q;

        if (cfg_valid && !pend_q) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_t'(cfg_mode);
            pend_div_d  = cfg_div;
        end

        // An apply-tick only loads start state; stepping resumes on the next tick.
        if (apply) begin
            pend_d = 1'b0;
            mode_d = pend_mode_q;
            pat_d  = (pend_mode_q == MODE_BINARY) ? '0 : PAT_ONE;
            bdir_d = 1'b0;
            duty_d = '0;
            ddir_d = 1'b0;
        end else if (tick_i) begin
            case (mode_q)
                MODE_BINARY: pat_d = pat_q + PAT_ONE;
                MODE_ROTATE: pat_d = (pat_q << 1) | (pat_q >> (NUM_LEDS-1));
                MODE_BOUNCE: begin
                    if (NUM_LEDS > 1) begin
                        if (!bdir_q) begin
                            pat_d = pat_q << 1;
                            if (pat_d == PAT_MSB)
                                bdir_d = 1'b1;
                        end else begin
                            pat_d = pat_q >> 1;
                            if (pat_d == PAT_ONE)
                                bdir_d = 1'b0;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (!ddir_q) begin
                        duty_d = duty_q + PWM_ONE;
                        if (duty_d == PWM_MAX)
                            ddir_d = 1'b1;
                    end else begin
                        duty_d = duty_q - PWM_ONE;
                        if (duty_d == '0)
                            ddir_d = 1'b0;
                    end
                end
                default: pat_d = pat_q;
            endcase
        end

        led_d = (mode_q == MODE_BREATHE) ? {NUM_LEDS{pwm_q < duty_q}} : pat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_BINARY;
            pend_mode_q <= MODE_BINARY;
            pend_div_q  <= '0;
            pend_q      <= 1'b0;
            pat_q       <= '0;
            bdir_q      <= 1'b0;
            duty_q      <= '0;
            ddir_q      <= 1'b0;
            pwm_q       <= '0;
            led_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_div_q  <= pend_div_d;
            pend_q      <= pend_d;
            pat_q       <= pat_d;
            bdir_q      <= bdir_d;
            duty_q      <= duty_d;
            ddir_q      <= ddir_d;
            pwm_q       <= pwm_q + PWM_ONE;
            led_q       <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: binary, rotate, bounce, breathe,
// handshake timing and asynchronous reset.
module tb_led_pattern_sequencer;

    localparam int NL = 5;
    localparam int DB = 8;
    localparam int PB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_mode = 2'd0;
    logic [DB-1:0] cfg_div = '0;
    logic [NL-1:0] led;
    logic          tick;

    int checks = 0;
    int errors = 0;
    int bseq[10] = '{1, 2, 4, 8, 16, 8, 4, 2, 1, 2};

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .NUM_LEDS    (NL),
        .DIV_BITS    (DB),
        .DEFAULT_DIV (4),
        .PWM_BITS    (PB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_div   (cfg_div),
        .led       (led),
        .tick      (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next tick cycle; checks distance and led there.
    task automatic step(input string tag, input int per, input int exp_led);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 64);
        chk({tag, "_period"}, n, per);
        if (exp_led >= 0)
            chk({tag, "_led"}, led, exp_led);
    endtask

    initial begin
        int ones, other, tk, exp_duty;

        repeat (3) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_tick", tick, 0);
        rst = 1'b0;

        for (int k = 1; k <= 34; k++)
            step($sformatf("bin%0d", k), (k == 1) ? 3 : 4, (k - 1) % 32);

        @(negedge clk);
        cfg_mode = 2'd1; cfg_div = 8'd2; cfg_valid = 1'b1;
        chk("rot_ready_before", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("rot_ready_pending", cfg_ready, 0);
        step("rot_apply", 2, 2);
        chk("rot_ready_at_apply", cfg_ready, 0);
        @(negedge clk);
        chk("rot_ready_after", cfg_ready, 1);
        chk("rot_no_tick", tick, 0);
        step("rot0", 1, 1);
        step("rot1", 2, 2);
        step("rot2", 2, 4);
        step("rot3", 2, 8);
        step("rot4", 2, 16);
        step("rot5", 2, 1);

        // Offer in a tick cycle and keep offering through the next tick.
        cfg_mode = 2'd2; cfg_div = 8'd0; cfg_valid = 1'b1;
        @(negedge clk);
        chk("hs_ready_t1", cfg_ready, 0);
        chk("hs_tick_t1", tick, 0);
        chk("hs_led_t1", led, 1);
        @(negedge clk);
        chk("hs_tick_apply", tick, 1);
        chk("hs_ready_apply", cfg_ready, 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("hs_ready_t3", cfg_ready, 1);
        chk("hs_tick_t3", tick, 1);
        chk("hs_led_t3", led, 2);
        @(negedge clk);
        chk("hs_ready_t4", cfg_ready, 1);
        chk("hs_tick_t4", tick, 1);
        chk("bnc0", led, bseq[0]);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bnc%0d", i), led, bseq[i]);
        end

        cfg_mode = 2'd3; cfg_div = 8'd8; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("br_tick_apply", tick, 1);
        chk("br_ready_apply", cfg_ready, 0);
        @(negedge clk);
        chk("br_ready_after", cfg_ready, 1);
        other = 0;
        for (int k = 0; k < 16; k++) begin
            ones = 0;
            tk = 0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                if (led == 5'b11111) ones++;
                else if (led != 5'b00000) other++;
                if (j == 6) tk = int'(tick);
            end
            exp_duty = (k <= 7) ? k : ((k <= 14) ? 14 - k : k - 14);
            chk($sformatf("br_duty%0d", k), ones, exp_duty);
            chk($sformatf("br_tick%0d", k), tk, 1);
        end
        chk("br_mixed_led", other, 0);

        cfg_mode = 2'd2; cfg_div = 8'd4; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("b4_ready_pending", cfg_ready, 0);
        step("b4_apply", 6, -1);
        @(negedge clk);
        chk("b4_ready_after", cfg_ready, 1);
        step("b4_t1", 3, 1);
        step("b4_t2", 4, 2);

        @(negedge clk);
        cfg_mode = 2'd1; cfg_div = 8'd2; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("ar_pending", cfg_ready, 0);
        #1 rst = 1'b1;
        #1;
        chk("ar_led", led, 0);
        chk("ar_ready", cfg_ready, 1);
        chk("ar_tick", tick, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step("ar_bin1", 3, 0);
        step("ar_bin2", 4, 1);
        step("ar_bin3", 4, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
